// File: rtl/plane_bit_plotter.sv
// Bitplane pixel plotter: steps a 4:1 bit mux through the colour planes and
// packs the returned bits into a 4bpp, 8-pixel character row.
module plane_bit_plotter #(
    parameter bit TRANSPARENT_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [3:0]  pix_color,
    input  logic [2:0]  pix_x,
    input  logic        flush,
    output logic [1:0]  mux_selector,
    output logic [3:0]  mux_data,
    input  logic        mux_bit,
    output logic        row_valid,
    input  logic        row_ready,
    output logic [31:0] row_data,
    output logic [7:0]  row_mask
);

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_c;
    logic [2:0]  r_x;
    logic [1:0]  r_k;
    logic [31:0] r_data;
    logic [7:0]  r_mask;

    logic        w_skip;
    logic [4:0]  w_bit_idx;
    logic [7:0]  w_mask_upd;

    assign w_skip     = TRANSPARENT_SKIP && (r_c == 4'h0);
    // bit 8k+7-X: plane k selects the byte, ~X is 7-X within it
    assign w_bit_idx  = {r_k, ~r_x};
    assign w_mask_upd = r_mask | (w_skip ? 8'h00 : (8'h80 >> r_x));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (pix_valid)                      w_next = SCAN;
                else if (flush && r_mask != 8'h00)  w_next = OUT;
            end
            SCAN: begin
                if (r_k == 2'd3) w_next = (w_mask_upd == 8'hFF) ? OUT : IDLE;
            end
            OUT: begin
                if (row_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // k saturates at 3 so the selector holds its last value outside SCAN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c    <= 4'h0;
            r_x    <= 3'd0;
            r_k    <= 2'd0;
            r_data <= 32'h0;
            r_mask <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pix_valid) begin
                        r_c <= pix_color;
                        r_x <= pix_x;
                        r_k <= 2'd0;
                    end
                end
                SCAN: begin
                    if (!w_skip) r_data[w_bit_idx] <= mux_bit;
                    if (r_k != 2'd3)  r_k <= r_k + 2'd1;
                    else if (!w_skip) r_mask <= w_mask_upd;
                end
                OUT: begin
                    if (row_ready) begin
                        r_data <= 32'h0;
                        r_mask <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_ready    = (r_state == IDLE);
    assign row_valid    = (r_state == OUT);
    assign mux_selector = r_k;
    assign mux_data     = r_c;
    assign row_data     = r_data;
    assign row_mask     = r_mask;

endmodule

// File: tb/tb_plane_bit_plotter.sv
// Directed bench for plane_bit_plotter with a behavioural 4:1 bit mux attached.
module tb_plane_bit_plotter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0, flush = 1'b0, row_ready = 1'b0;
    logic [3:0]  pix_color = 4'h0;
    logic [2:0]  pix_x = 3'd0;
    logic        pix_ready, row_valid, mux_bit;
    logic [1:0]  mux_selector;
    logic [3:0]  mux_data;
    logic [31:0] row_data;
    logic [7:0]  row_mask;

    // second instance with transparency disabled
    logic        v0 = 1'b0, f0 = 1'b0, r0 = 1'b0;
    logic        pr0, rv0, mb0;
    logic [1:0]  sel0;
    logic [3:0]  md0;
    logic [31:0] data0;
    logic [7:0]  mask0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign mux_bit = mux_data[mux_selector];
    assign mb0     = md0[sel0];

    plane_bit_plotter #(.TRANSPARENT_SKIP(1'b1)) u_dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_color(pix_color), .pix_x(pix_x), .flush(flush),
        .mux_selector(mux_selector), .mux_data(mux_data), .mux_bit(mux_bit),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_mask(row_mask)
    );

    plane_bit_plotter #(.TRANSPARENT_SKIP(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .pix_valid(v0), .pix_ready(pr0),
        .pix_color(pix_color), .pix_x(pix_x), .flush(f0),
        .mux_selector(sel0), .mux_data(md0), .mux_bit(mb0),
        .row_valid(rv0), .row_ready(r0), .row_data(data0),
        .row_mask(mask0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!pix_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("wait_ready", 32'(pix_ready), 32'd1);
    endtask

    // called just after a negedge; returns at the negedge of cycle n+1
    task automatic accept(input logic [3:0] c, input logic [2:0] x);
        wait_ready();
        pix_valid = 1'b1;
        pix_color = c;
        pix_x     = x;
        @(posedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   cnt;
        logic flag;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(pix_ready), 32'd1);
        chk("rst_sel",   32'(mux_selector), 32'd0);
        chk("rst_mdata", 32'(mux_data), 32'd0);
        chk("rst_valid", 32'(row_valid), 32'd0);
        chk("rst_data",  row_data, 32'h0);
        chk("rst_mask",  32'(row_mask), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // full row, colours 1..8 at x 0..7
        row_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            accept(4'(i + 1), 3'(i));
            if (i < 7) begin
                cnt = 1;
                while (!pix_ready && cnt < 20) begin
                    @(negedge clk);
                    if (!pix_ready) cnt++;
                end
                chk("busy_cycles", 32'(cnt), 32'd4);
            end
        end
        flag = 1'b0;
        repeat (4) begin
            flag |= row_valid;
            @(negedge clk);
        end
        chk("full_early",  32'(flag), 32'd0);
        chk("full_valid",  32'(row_valid), 32'd1);
        chk("full_data",   row_data, 32'h011E66AA);
        chk("full_mask",   32'(row_mask), 32'hFF);
        @(negedge clk);
        chk("full_hs_rdy",  32'(pix_ready), 32'd1);
        chk("full_hs_mask", 32'(row_mask), 32'h0);
        chk("full_hs_vld",  32'(row_valid), 32'd0);

        // selector sequence
        accept(4'hA, 3'd5);
        for (int k = 0; k < 4; k++) begin
            chk("sel_seq",  32'(mux_selector), 32'(k));
            chk("sel_data", 32'(mux_data), 32'hA);
            @(negedge clk);
        end
        chk("sel_rowdata", row_data, 32'h04000400);
        chk("sel_mask",    32'(row_mask), 32'h04);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_valid", 32'(row_valid), 32'd1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_clr", 32'(row_mask), 32'h0);

        // transparency with skip enabled
        accept(4'h0, 3'd3);
        wait_ready();
        flush = 1'b1;
        flag  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            flag |= row_valid;
        end
        flush = 1'b0;
        chk("skip_novalid", 32'(flag), 32'd0);
        chk("skip_mask",    32'(row_mask), 32'h0);

        // transparency with skip disabled
        v0 = 1'b1; pix_color = 4'h0; pix_x = 3'd3;
        @(negedge clk);
        v0 = 1'b0;
        repeat (4) @(negedge clk);
        f0 = 1'b1;
        @(negedge clk);
        chk("noskip_valid", 32'(rv0), 32'd1);
        chk("noskip_mask",  32'(mask0), 32'h10);
        chk("noskip_data",  data0, 32'h0);
        r0 = 1'b1;
        @(negedge clk);
        f0 = 1'b0; r0 = 1'b0;
        chk("noskip_clr", 32'(mask0), 32'h0);

        // partial flush with simultaneous pixel
        row_ready = 1'b0;
        accept(4'hF, 3'd7);
        wait_ready();
        pix_valid = 1'b1; pix_color = 4'h1; pix_x = 3'd0; flush = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        chk("simul_accept", 32'(pix_ready), 32'd0);
        cnt = 0;
        while (!row_valid && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("simul_lat",  32'(cnt), 32'd5);
        chk("simul_mask", 32'(row_mask), 32'h81);
        chk("simul_data", row_data, 32'h01010181);
        flush = 1'b0; row_ready = 1'b1;
        @(negedge clk);
        chk("simul_clr", 32'(row_valid), 32'd0);
        row_ready = 1'b0;

        // output backpressure
        for (int i = 0; i < 8; i++) accept(4'(8 + i), 3'(i));
        cnt = 0;
        while (!row_valid && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("bp_valid", 32'(row_valid), 32'd1);
        chk("bp_data0", row_data, 32'hFF0F3355);
        pix_valid = 1'b1; pix_color = 4'h3; pix_x = 3'd2;
        repeat (10) begin
            @(negedge clk);
            chk("bp_ready", 32'(pix_ready), 32'd0);
            chk("bp_data",  row_data, 32'hFF0F3355);
        end
        row_ready = 1'b1;
        @(negedge clk);
        chk("bp_clr_mask", 32'(row_mask), 32'h0);
        chk("bp_clr_vld",  32'(row_valid), 32'd0);
        chk("bp_clr_rdy",  32'(pix_ready), 32'd1);
        row_ready = 1'b0;
        @(negedge clk);
        pix_valid = 1'b0;
        chk("bp_pend_acc", 32'(pix_ready), 32'd0);
        repeat (4) @(negedge clk);
        chk("bp_pend_mask", 32'(row_mask), 32'h20);
        chk("bp_pend_data", row_data, 32'h00002020);

        // asynchronous reset during SCAN k=2
        accept(4'h5, 3'd1);
        repeat (2) @(negedge clk);
        chk("mid_sel", 32'(mux_selector), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("ar_ready", 32'(pix_ready), 32'd1);
        chk("ar_sel",   32'(mux_selector), 32'd0);
        chk("ar_mdata", 32'(mux_data), 32'd0);
        chk("ar_valid", 32'(row_valid), 32'd0);
        chk("ar_data",  row_data, 32'h0);
        chk("ar_mask",  32'(row_mask), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("ar_rel_rdy", 32'(pix_ready), 32'd1);
        accept(4'h6, 3'd4);
        repeat (4) @(negedge clk);
        chk("ar_next_mask", 32'(row_mask), 32'h08);
        chk("ar_next_data", row_data, 32'h00080800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
